// File: rtl/seg7_bcd_counter.sv
`timescale 1ns/1ps
// Four-digit BCD stopwatch with clock prescaler and debounced start/clear keys.
// Latency: a key press changes running/digits 3 edges after its first low sample.
// Backpressure: none; keys are free-running inputs and digit outputs are always valid.
module seg7_bcd_counter #(
  parameter int CLK_DIV = 500000,
  parameter int DIV_W   = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       running,
  output logic       tick,
  output logic       ovf
);

  localparam logic [0:0]       ST_STOP = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;
  localparam logic [DIV_W-1:0] TC      = DIV_W'(CLK_DIV - 1);

  logic [2:0]       start_sync;
  logic [2:0]       clear_sync;
  logic             start_evt;
  logic             clear_evt;
  logic [0:0]       state;
  logic [DIV_W-1:0] presc;
  logic [3:0][3:0]  digs;
  logic [3:0][3:0]  nxt_digs;
  logic             inc_carry;

  // Bit 0 is the first synchroniser stage, bit 2 the history flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_sync <= 3'b111;
      clear_sync <= 3'b111;
      start_evt  <= 1'b0;
      clear_evt  <= 1'b0;
    end else begin
      start_sync <= {start_sync[1:0], key_start_n};
      clear_sync <= {clear_sync[1:0], key_clear_n};
      start_evt  <= start_sync[2] & ~start_sync[1];
      clear_evt  <= clear_sync[2] & ~clear_sync[1];
    end
  end

  always_comb begin
    nxt_digs  = digs;
    inc_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_carry) begin
        if (digs[i] == 4'd9) begin
          nxt_digs[i] = 4'd0;
        end else begin
          nxt_digs[i] = digs[i] + 4'd1;
          inc_carry   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_STOP;
      presc <= '0;
      digs  <= '0;
      tick  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear_evt) begin
        state <= ST_STOP;
        presc <= '0;
        digs  <= '0;
        ovf   <= 1'b0;
      end else if (state == ST_RUN) begin
        // Stopping holds the prescaler and drops a terminal-count increment.
        if (start_evt) begin
          state <= ST_STOP;
        end else if (presc == TC) begin
          presc <= '0;
          tick  <= 1'b1;
          digs  <= nxt_digs;
          if (inc_carry) ovf <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end else if (start_evt) begin
        state <= ST_RUN;
      end
    end
  end

  assign dig0    = digs[0];
  assign dig1    = digs[1];
  assign dig2    = digs[2];
  assign dig3    = digs[3];
  assign running = (state == ST_RUN);

endmodule

// File: tb/tb_seg7_bcd_counter.sv
`timescale 1ns/1ps
// Directed bench for seg7_bcd_counter with CLK_DIV=4: vector table plus multi-cycle sequences.
module tb_seg7_bcd_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start_n;
  logic       key_clear_n;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       running, tick, ovf;
  logic [15:0] dig_all;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_val = 0;
  logic exp_ovf = 1'b0;

  typedef struct {
    logic        ks;
    logic        kc;
    logic        run;
    logic        tk;
    logic [15:0] dig;
  } vec_t;
  vec_t vecs[$];

  seg7_bcd_counter #(.CLK_DIV(4), .DIV_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .key_start_n(key_start_n), .key_clear_n(key_clear_n),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .running(running), .tick(tick), .ovf(ovf)
  );

  always #5 clk = ~clk;
  assign dig_all = {dig3, dig2, dig1, dig0};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // {running, tick, ovf, digits}
  task automatic check_stat(input string name, input logic r, input logic t, input logic o,
                            input logic [15:0] d);
    check(name, {13'd0, running, tick, ovf, dig_all}, {13'd0, r, t, o, d});
  endtask

  task automatic add(input logic ks, input logic kc, input logic r, input logic t, input int d);
    vec_t v;
    v.ks = ks; v.kc = kc; v.run = r; v.tk = t; v.dig = to_bcd(d);
    vecs.push_back(v);
  endtask

  // Waits for n ticks; digits must hold between ticks and step on each tick.
  task automatic expect_ticks(input int n, input bit check_first_gap);
    for (int t = 0; t < n; t++) begin
      int cnt;
      bit seen;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 12) begin
        @(negedge clk);
        cnt++;
        if (tick) seen = 1'b1;
        else check("hold_digits", {16'd0, dig_all}, {16'd0, to_bcd(exp_val)});
      end
      check("tick_seen", {31'd0, seen}, 32'd1);
      exp_val = (exp_val + 1) % 10000;
      if (exp_val == 0) exp_ovf = 1'b1;
      check("tick_digits", {15'd0, ovf, dig_all}, {15'd0, exp_ovf, to_bcd(exp_val)});
      if (t > 0 || check_first_gap) check("tick_gap", cnt, 4);
    end
  endtask

  task automatic press_start();
    key_start_n = 1'b0;
    repeat (3) @(negedge clk);
    key_start_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_stat("reset_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
    end

    // Start held 5 cycles, first ticks, then a clear press while running
    for (int i = 0; i < 3; i++)  add(1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2; i++)  add(1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 2; i++)  add(1'b1, 1'b1, 1'b1, 1'b0, 0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++)  add(1'b1, 1'b1, 1'b1, 1'b0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 2);
    for (int i = 0; i < 3; i++)  add(1'b1, 1'b1, 1'b1, 1'b0, 2);
    add(1'b1, 1'b1, 1'b1, 1'b1, 3);
    add(1'b1, 1'b1, 1'b1, 1'b0, 3);
    for (int i = 0; i < 2; i++)  add(1'b1, 1'b0, 1'b1, 1'b0, 3);
    add(1'b1, 1'b1, 1'b1, 1'b1, 4);
    for (int i = 0; i < 3; i++)  add(1'b1, 1'b1, 1'b0, 1'b0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      key_start_n = vecs[i].ks;
      key_clear_n = vecs[i].kc;
      @(negedge clk);
      check_stat($sformatf("vec%0d", i), vecs[i].run, vecs[i].tk, 1'b0, vecs[i].dig);
    end

    // Full sweep through every carry boundary and the 9999 wrap
    exp_val = 0;
    exp_ovf = 1'b0;
    press_start();
    expect_ticks(10003, 1'b0);
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    key_clear_n = 1'b0;
    repeat (2) @(negedge clk);
    key_clear_n = 1'b1;
    repeat (2) @(negedge clk);
    check_stat("clear_after_ovf", 1'b0, 1'b0, 1'b0, 16'h0000);
    exp_val = 0;
    exp_ovf = 1'b0;

    // Stop mid-period with prescaler at 2, then resume
    press_start();
    expect_ticks(1, 1'b0);
    repeat (3) @(negedge clk);
    key_start_n = 1'b0;
    @(negedge clk);
    check_stat("tick_before_stop", 1'b1, 1'b1, 1'b0, to_bcd(2));
    @(negedge clk);
    key_start_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_stat("stopped", 1'b0, 1'b0, 1'b0, to_bcd(2));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_stat("frozen", 1'b0, 1'b0, 1'b0, to_bcd(2));
    end
    key_start_n = 1'b0;
    repeat (2) @(negedge clk);
    key_start_n = 1'b1;
    @(negedge clk);
    check_stat("resume_pending", 1'b0, 1'b0, 1'b0, to_bcd(2));
    @(negedge clk);
    check_stat("resumed", 1'b1, 1'b0, 1'b0, to_bcd(2));
    @(negedge clk);
    check_stat("resume_p3", 1'b1, 1'b0, 1'b0, to_bcd(2));
    @(negedge clk);
    check_stat("resume_tick", 1'b1, 1'b1, 1'b0, to_bcd(3));
    exp_val = 3;

    // Simultaneous start and clear at 0042, landing on a terminal-count edge
    expect_ticks(39, 1'b1);
    key_start_n = 1'b0;
    key_clear_n = 1'b0;
    repeat (2) @(negedge clk);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (2) @(negedge clk);
    check_stat("clear_wins", 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (6) @(negedge clk);
    check_stat("start_discarded", 1'b0, 1'b0, 1'b0, 16'h0000);
    exp_val = 0;

    // Reset asserted exactly at a terminal-count edge
    press_start();
    expect_ticks(1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_stat("reset_at_tc", 1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_stat("after_reset", 1'b0, 1'b0, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
